// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared loader state encoding and default RAM geometry
package ram_loader_pkg;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loader_state_t;
endpackage

// File: rtl/ram_stream_loader.sv
// ram_stream_loader: valid/ready word stream to sequential single-port RAM writes
// Optional frame checksum enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_stream_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] checksum
);
  loader_state_t state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0] len;
  logic accept;
  assign s_ready = state == LOAD;
  assign busy = state != IDLE;
  assign accept = s_valid && s_ready;
  // done is registered from DONE, so it appears in the cycle after DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      count <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wr_en <= 1'b0;
      done <= 1'b0;
    end else begin
      ram_wr_en <= accept;
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          len <= length;
          count <= '0;
          state <= (length == '0) ? DONE : LOAD;
        end
        LOAD: if (accept) begin
          ram_addr <= base + count[ADDR_WIDTH-1:0];
          ram_data <= s_data;
          count <= count + 1'b1;
          state <= (count + 1'b1 == len) ? FLUSH : LOAD;
        end
        FLUSH: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (accept) checksum <= checksum + s_data;
  end
`else
  assign checksum = '0;
`endif
endmodule
